// File: rtl/layer_compositor.sv
// Two-stage sprite-layer compositor: priority colour-class select, day/night palette map,
// and per-frame collision detection between two programmable layer groups.
module layer_compositor #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned COORD_W    = 11,
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned SCREEN_H   = 480,
  parameter int unsigned RW         = 3,
  parameter int unsigned GW         = 3,
  parameter int unsigned BW         = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_en,
  input  logic                  frame_start,
  input  logic [COORD_W-1:0]    vga_x,
  input  logic [COORD_W-1:0]    vga_y,
  input  logic [NUM_LAYERS-1:0] layer_grey,
  input  logic [NUM_LAYERS-1:0] layer_white,
  input  logic [NUM_LAYERS-1:0] grp_a_mask,
  input  logic [NUM_LAYERS-1:0] grp_b_mask,
  input  logic                  night_req,
  output logic [RW-1:0]         vgaRed,
  output logic [GW-1:0]         vgaGreen,
  output logic [BW-1:0]         vgaBlue,
  output logic                  collision,
  output logic                  collision_rise,
  output logic                  night_active
);

  typedef enum logic [1:0] {
    ClsOff,
    ClsBg,
    ClsDark,
    ClsLight
  } cls_e;

  localparam logic [COORD_W-1:0] XLim = COORD_W'(SCREEN_W);
  localparam logic [COORD_W-1:0] YLim = COORD_W'(SCREEN_H);

  logic                  w_active;
  logic [NUM_LAYERS-1:0] w_layers;
  logic                  w_hit;
  cls_e                  w_cls;
  logic                  w_light;

  cls_e          r_cls;
  logic [RW-1:0] r_red;
  logic [GW-1:0] r_green;
  logic [BW-1:0] r_blue;
  logic          r_acc;
  logic          r_coll;
  logic          r_rise;
  logic          r_night;

  assign w_active = (vga_x < XLim) && (vga_y < YLim);
  assign w_layers = layer_grey | layer_white;
  assign w_hit    = w_active & (|(w_layers & grp_a_mask)) & (|(w_layers & grp_b_mask));

  // Walk from lowest priority upward so the lowest active index overwrites the rest.
  always_comb begin
    w_cls = ClsBg;
    for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
      if (layer_grey[i]) begin
        w_cls = ClsDark;
      end else if (layer_white[i]) begin
        w_cls = ClsLight;
      end
    end
    if (!w_active) begin
      w_cls = ClsOff;
    end
  end

  // Blanking is never inverted by the night palette.
  always_comb begin
    w_light = 1'b0;
    unique case (r_cls)
      ClsDark:         w_light = r_night;
      ClsLight, ClsBg: w_light = ~r_night;
      ClsOff:          w_light = 1'b0;
      default:         w_light = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cls   <= ClsOff;
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
      r_acc   <= 1'b0;
      r_coll  <= 1'b0;
      r_rise  <= 1'b0;
      r_night <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      if (pix_en) begin
        r_cls   <= w_cls;
        r_red   <= {RW{w_light}};
        r_green <= {GW{w_light}};
        r_blue  <= {BW{w_light}};
        if (frame_start) begin
          // The frame_start pixel's hit belongs to the new frame, not the latched one.
          r_coll  <= r_acc;
          r_rise  <= r_acc & ~r_coll;
          r_acc   <= w_hit;
          r_night <= night_req;
        end else begin
          r_acc <= r_acc | w_hit;
        end
      end
    end
  end

  assign vgaRed         = r_red;
  assign vgaGreen       = r_green;
  assign vgaBlue        = r_blue;
  assign collision      = r_coll;
  assign collision_rise = r_rise;
  assign night_active   = r_night;

endmodule

// File: tb/tb_layer_compositor.sv
// Randomised bench for layer_compositor: a pixel-level reference model predicts colour,
// palette and collision outputs every clock, plus directed scenarios for the corner cases.
module tb_layer_compositor;

  logic        clk;
  logic        rst;
  logic        pix_en;
  logic        frame_start;
  logic [10:0] vga_x;
  logic [10:0] vga_y;
  logic [3:0]  layer_grey;
  logic [3:0]  layer_white;
  logic [3:0]  grp_a_mask;
  logic [3:0]  grp_b_mask;
  logic        night_req;
  logic [2:0]  vgaRed;
  logic [2:0]  vgaGreen;
  logic [1:0]  vgaBlue;
  logic        collision;
  logic        collision_rise;
  logic        night_active;

  layer_compositor dut (
    .clk           (clk),
    .rst           (rst),
    .pix_en        (pix_en),
    .frame_start   (frame_start),
    .vga_x         (vga_x),
    .vga_y         (vga_y),
    .layer_grey    (layer_grey),
    .layer_white   (layer_white),
    .grp_a_mask    (grp_a_mask),
    .grp_b_mask    (grp_b_mask),
    .night_req     (night_req),
    .vgaRed        (vgaRed),
    .vgaGreen      (vgaGreen),
    .vgaBlue       (vgaBlue),
    .collision     (collision),
    .collision_rise(collision_rise),
    .night_active  (night_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, expressed per pixel and per frame.
  logic [7:0] m_prev_colour;
  logic [7:0] m_rgb;
  logic       m_frame_night;
  logic       m_frame_hit;
  logic       m_coll;
  logic       m_rise;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [7:0] ref_colour(input int x, input int y, input logic [3:0] g,
                                            input logic [3:0] w, input logic night);
    if (x >= 640 || y >= 480) return 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) return night ? 8'hFF : 8'h00;
      if (w[i]) return night ? 8'h00 : 8'hFF;
    end
    return night ? 8'h00 : 8'hFF;
  endfunction

  function automatic logic ref_hit(input int x, input int y, input logic [3:0] g,
                                   input logic [3:0] w, input logic [3:0] a, input logic [3:0] b);
    int in_a;
    int in_b;
    in_a = 0;
    in_b = 0;
    if (x >= 640 || y >= 480) return 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((g[i] || w[i]) && a[i]) in_a++;
      if ((g[i] || w[i]) && b[i]) in_b++;
    end
    return (in_a > 0) && (in_b > 0);
  endfunction

  task automatic model_clock();
    logic night_eff;
    logic hit;
    m_rise = 1'b0;
    if (rst) begin
      m_prev_colour = 8'h00;
      m_rgb         = 8'h00;
      m_frame_night = 1'b0;
      m_frame_hit   = 1'b0;
      m_coll        = 1'b0;
    end else if (pix_en) begin
      night_eff = frame_start ? night_req : m_frame_night;
      hit = ref_hit(int'(vga_x), int'(vga_y), layer_grey, layer_white, grp_a_mask, grp_b_mask);
      m_rgb = m_prev_colour;
      m_prev_colour = ref_colour(int'(vga_x), int'(vga_y), layer_grey, layer_white, night_eff);
      if (frame_start) begin
        m_rise        = m_frame_hit && !m_coll;
        m_coll        = m_frame_hit;
        m_frame_hit   = hit;
        m_frame_night = night_req;
      end else begin
        m_frame_hit = m_frame_hit || hit;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check("rgb", {vgaRed, vgaGreen, vgaBlue}, m_rgb);
    check("night", night_active, m_frame_night);
    check("coll", collision, m_coll);
    check("rise", collision_rise, m_rise);
  endtask

  // Idle clocks carry garbage on the data inputs to prove pix_en gating.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      pix_en      = 1'b0;
      frame_start = 1'($urandom_range(0, 1));
      vga_x       = 11'($urandom_range(0, 700));
      vga_y       = 11'($urandom_range(0, 500));
      layer_grey  = 4'($urandom);
      layer_white = 4'($urandom);
      step();
    end
  endtask

  task automatic pixel(input int x, input int y, input logic [3:0] g, input logic [3:0] w,
                       input logic fs);
    idle($urandom_range(0, 2));
    pix_en      = 1'b1;
    frame_start = fs;
    vga_x       = 11'(x);
    vga_y       = 11'(y);
    layer_grey  = g;
    layer_white = w;
    step();
    pix_en      = 1'b0;
    frame_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b0; frame_start = 1'b0; vga_x = '0; vga_y = '0;
    layer_grey = '0; layer_white = '0; grp_a_mask = '0; grp_b_mask = '0; night_req = 1'b0;
    m_prev_colour = 8'hFF; m_rgb = 8'hFF; m_frame_night = 1'b1;
    m_frame_hit = 1'b1; m_coll = 1'b1; m_rise = 1'b0;
    step();
    step();
    check("reset_rgb", {vgaRed, vgaGreen, vgaBlue}, 8'h00);
    rst = 1'b0;

    // Priority: grey on layer 0 beats white on layer 1.
    pixel(10, 10, 4'b0001, 4'b0010, 1'b1);
    pixel(10, 10, 4'b0000, 4'b0010, 1'b0);
    check("t1_dark", {vgaRed, vgaGreen, vgaBlue}, 8'h00);
    pixel(0, 0, 4'b0000, 4'b0000, 1'b0);
    check("t1_light", {vgaRed, vgaGreen, vgaBlue}, 8'hFF);

    // Night requested mid-frame: day palette holds, blanking stays dark.
    night_req = 1'b1;
    pixel(700, 10, 4'b1111, 4'b1111, 1'b0);
    pixel(20, 20, 4'b0000, 4'b0000, 1'b0);
    check("t2_day_blank", {vgaRed, vgaGreen, vgaBlue}, 8'h00);
    pixel(20, 20, 4'b0000, 4'b0000, 1'b0);
    check("t3_hold", {vgaRed, vgaGreen, vgaBlue}, 8'hFF);
    check("t3_hold_nt", night_active, 1'b0);
    pixel(0, 0, 4'b0000, 4'b0000, 1'b1);
    check("t3_nt", night_active, 1'b1);
    pixel(5, 5, 4'b0001, 4'b0000, 1'b0);
    check("t3_bg", {vgaRed, vgaGreen, vgaBlue}, 8'h00);
    pixel(700, 10, 4'b1111, 4'b0000, 1'b0);
    check("t3_grey", {vgaRed, vgaGreen, vgaBlue}, 8'hFF);
    pixel(6, 6, 4'b0000, 4'b0000, 1'b0);
    check("t2_night_blank", {vgaRed, vgaGreen, vgaBlue}, 8'h00);
    night_req = 1'b0;

    // Collision between layer 0 (group A) and layer 1 (group B).
    grp_a_mask = 4'b0001;
    grp_b_mask = 4'b0010;
    pixel(0, 0, 4'b0000, 4'b0000, 1'b1);
    pixel(100, 300, 4'b0001, 4'b0010, 1'b0);
    pixel(1, 1, 4'b0000, 4'b0000, 1'b0);
    pixel(0, 0, 4'b0000, 4'b0000, 1'b1);
    check("t4_coll", collision, 1'b1);
    check("t4_rise", collision_rise, 1'b1);
    step();
    check("t4_rise_once", collision_rise, 1'b0);
    pixel(2, 2, 4'b0000, 4'b0000, 1'b0);
    pixel(0, 0, 4'b0000, 4'b0000, 1'b1);
    check("t4_clear", collision, 1'b0);

    // Hit on the frame_start pixel is reported one frame later.
    pixel(100, 300, 4'b0011, 4'b0000, 1'b1);
    check("t5_not_now", collision, 1'b0);
    pixel(3, 3, 4'b0000, 4'b0000, 1'b0);
    pixel(0, 0, 4'b0000, 4'b0000, 1'b1);
    check("t5_later", collision, 1'b1);

    // Long stall, then reset mid-frame with the accumulator set.
    idle(20);
    check("t6_stall_coll", collision, 1'b1);
    pixel(100, 300, 4'b0011, 4'b0000, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_coll", collision, 1'b0);
    check("t6_rst_rgb", {vgaRed, vgaGreen, vgaBlue}, 8'h00);
    pixel(1, 1, 4'b0000, 4'b0000, 1'b0);
    pixel(0, 0, 4'b0000, 4'b0000, 1'b1);
    check("t6_after_rst", collision, 1'b0);

    // Random frames of short random scans.
    for (int f = 0; f < 30; f++) begin
      grp_a_mask = 4'($urandom);
      grp_b_mask = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
      for (int p = 0; p < 30; p++) begin
        if ($urandom_range(0, 9) == 0) night_req = ~night_req;
        if ($urandom_range(0, 199) == 0) begin
          rst = 1'b1;
          step();
          rst = 1'b0;
        end
        pixel($urandom_range(0, 720), $urandom_range(0, 520),
              4'($urandom & $urandom & $urandom), 4'($urandom & $urandom), p == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
